// File: rtl/apb_cat_slave.sv
// APB slave front-end for CatRecognizer: CTRL/status register, image-memory
// write/read forwarding and the start/done handshake with the compute core.
module apb_cat_slave #(
  parameter int AMBA_WORD  = 24,
  parameter int ADDR_DEPTH = 12,
  parameter int IMG_WORDS  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_DEPTH:0]   PADDR,
  input  logic [AMBA_WORD-1:0]  PWDATA,
  output logic [AMBA_WORD-1:0]  PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_DEPTH-1:0] mem_addr,
  output logic [AMBA_WORD-1:0]  mem_wdata,
  input  logic [AMBA_WORD-1:0]  mem_rdata,
  output logic                  start_o,
  input  logic                  done_i,
  input  logic                  result_i
);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RD_DONE} state_e;

  localparam logic [ADDR_DEPTH:0]   LAST_IMG = IMG_WORDS[ADDR_DEPTH:0];
  localparam logic [ADDR_DEPTH-1:0] IDX_ONE  = 1;

  state_e                 state_q;
  logic                   penable_q;
  logic                   busy_q, done_q, result_q, ctrl_start_q, start_q;
  logic                   mem_we_q;
  logic [ADDR_DEPTH-1:0]  mem_addr_q, mem_addr_d;
  logic [AMBA_WORD-1:0]   mem_wdata_q, prdata_q, status;

  logic fire, is_ctrl, is_img, is_bad;
  logic wr_ctrl, wr_img_ok, rd_img, rd_ctrl, start_ok, start_blocked;

  // A transfer is decoded once, on the cycle PENABLE rises in IDLE; a held
  // PENABLE (or one still high coming out of reset) never re-triggers.
  assign fire    = PSEL & PENABLE & ~penable_q & (state_q == S_IDLE);
  assign is_ctrl = (PADDR == '0);
  assign is_img  = ~is_ctrl & (PADDR <= LAST_IMG);
  assign is_bad  = (PADDR > LAST_IMG);

  assign start_blocked = busy_q | start_q;
  assign wr_ctrl       = fire & PWRITE & is_ctrl;
  assign wr_img_ok     = fire & PWRITE & is_img & ~busy_q;
  assign rd_img        = fire & ~PWRITE & is_img;
  assign rd_ctrl       = fire & ~PWRITE & is_ctrl;
  assign start_ok      = wr_ctrl & PWDATA[0] & ~start_blocked;

  assign mem_addr_d = PADDR[ADDR_DEPTH-1:0] - IDX_ONE;

  always_comb begin
    // NOTE: every combinationally driven variable gets a default first so no latch is inferred.
    status      = '0;
    status[3:0] = {result_q, done_q, busy_q, ctrl_start_q};
  end

  // Zero-wait transfers complete on the decode cycle, so their response is combinational.
  always_comb begin
    PRDATA = '0;
    if (rd_ctrl)                    PRDATA = status;
    else if (state_q == S_RD_DONE)  PRDATA = prdata_q;
  end

  assign PREADY  = (state_q == S_IDLE) ? ~rd_img : (state_q == S_RD_DONE);
  assign PSLVERR = fire & (is_bad | (PWRITE & is_img & busy_q)
                           | (wr_ctrl & PWDATA[0] & start_blocked));

  // Read strobe and address go out on the decode cycle so the memory's
  // one-cycle latency lands in RD_WAIT.
  assign mem_re    = rd_img;
  assign mem_addr  = rd_img ? mem_addr_d : mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign start_o   = start_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      penable_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= 1'b0;
      ctrl_start_q <= 1'b0;
      start_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      prdata_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      penable_q <= PENABLE;
      mem_we_q  <= wr_img_ok;
      start_q   <= start_ok;

      if (wr_img_ok) begin
        mem_addr_q  <= mem_addr_d;
        mem_wdata_q <= PWDATA;
      end
      if (wr_ctrl) ctrl_start_q <= PWDATA[0];

      // busy_q above is the pre-update value, so a start or image write
      // coincident with done_i is still rejected.
      if (done_i) begin
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        result_q <= result_i;
      end
      if (start_ok) begin
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end

      case (state_q)
        S_IDLE:    if (rd_img) state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          prdata_q <= mem_rdata;
          state_q  <= S_RD_DONE;
        end
        S_RD_DONE: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cat_slave.sv
// Self-checking bench for apb_cat_slave: directed vector table, reset and
// held-PENABLE sequences, then random traffic against a transaction-level model.
module tb_apb_cat_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        PSEL, PENABLE, PWRITE;
  logic [12:0] PADDR;
  logic [23:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        mem_we, mem_re;
  logic [11:0] mem_addr;
  logic [23:0] mem_wdata, mem_rdata;
  logic        start_o, done_i, result_i;

  int n_checks = 0;
  int n_err    = 0;
  int we_count = 0;
  int st_count = 0;
  int exp_we_total = 0;
  int exp_st_total = 0;
  logic start_prev = 1'b0;

  apb_cat_slave dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .start_o(start_o),
    .done_i(done_i), .result_i(result_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Image memory with one-cycle read latency.
  logic [23:0] tb_mem [4096];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= tb_mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we) we_count++;
    if (start_o) begin
      st_count++;
      check("start_single_cycle", 32'(start_prev), 32'd0);
    end
    start_prev <= start_o;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One APB transfer; optionally pulses done_i on the decode cycle.
  task automatic apb(input bit w, input logic [12:0] a, input logic [23:0] d,
                     input bit wd, input bit res,
                     output logic [23:0] rd, output logic err, output int waits);
    bit ready;
    ready = 0; waits = 0; rd = '0; err = 1'b0;
    @(negedge clk);
    PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d;
    @(negedge clk);
    PENABLE = 1; done_i = wd; result_i = res;
    while (!ready && waits < 8) begin
      #1;
      if (PREADY) begin
        rd = PRDATA; err = PSLVERR; ready = 1;
      end
      @(posedge clk); #1;
      done_i = 0;
      if (!ready) begin
        waits++;
        @(negedge clk);
      end
    end
    PSEL = 0; PENABLE = 0;
  endtask

  typedef struct {
    bit          w;
    logic [12:0] a;
    logic [23:0] d;
    bit          wd;
    bit          res;
    logic [23:0] exp_rd;
    bit          exp_err;
    int          exp_waits;
    bit          exp_we;
    bit          exp_st;
    logic [11:0] exp_maddr;
  } vec_t;

  function automatic vec_t mk(bit w, logic [12:0] a, logic [23:0] d, bit wd, bit res,
                              logic [23:0] rd, bit err, int waits, bit we, bit st,
                              logic [11:0] ma);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.wd = wd; v.res = res; v.exp_rd = rd; v.exp_err = err;
    v.exp_waits = waits; v.exp_we = we; v.exp_st = st; v.exp_maddr = ma;
    return v;
  endfunction

  // Transaction-level model of the slave's architectural state.
  bit m_busy, m_done, m_res, m_ctrl;
  logic [23:0] m_mem [int];

  task automatic step(input bit w, input logic [12:0] a, input logic [23:0] d,
                      input bit wd, input bit res);
    bit ctrl, img, bad, exp_err, exp_we, exp_st;
    int exp_waits, waits;
    logic [23:0] exp_rd, rd;
    logic err;
    ctrl = (a == 0);
    img  = (a >= 1) && (a <= 4096);
    bad  = (a > 4096);
    exp_err   = bad || (w && img && m_busy) || (w && ctrl && d[0] && m_busy);
    exp_we    = w && img && !m_busy;
    exp_st    = w && ctrl && d[0] && !m_busy;
    exp_waits = (!w && img) ? 2 : 0;
    exp_rd    = '0;
    if (!w && ctrl)     exp_rd = {20'd0, m_res, m_done, m_busy, m_ctrl};
    else if (!w && img) exp_rd = m_mem[int'(a) - 1];
    apb(w, a, d, wd, res, rd, err, waits);
    check("rnd_err", 32'(err), 32'(exp_err));
    check("rnd_waits", 32'(waits), 32'(exp_waits));
    if (!w) check("rnd_rdata", 32'(rd), 32'(exp_rd));
    check("rnd_mem_we", 32'(mem_we), 32'(exp_we));
    check("rnd_start", 32'(start_o), 32'(exp_st));
    if (exp_we) begin
      check("rnd_mem_addr", 32'(mem_addr), 32'(int'(a) - 1));
      check("rnd_mem_wdata", 32'(mem_wdata), 32'(d));
      m_mem[int'(a) - 1] = d;
    end
    if (w && ctrl) m_ctrl = d[0];
    if (wd) begin m_busy = 0; m_done = 1; m_res = res; end
    if (exp_st) begin m_busy = 1; m_done = 0; end
    if (exp_we) exp_we_total++;
    if (exp_st) exp_st_total++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_prdata"},    32'(PRDATA),    32'd0);
    check({tag, "_pready"},    32'(PREADY),    32'd1);
    check({tag, "_pslverr"},   32'(PSLVERR),   32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_re"},    32'(mem_re),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_start"},     32'(start_o),   32'd0);
  endtask

  vec_t tbl [$];
  logic [12:0] img_list [16];

  initial begin
    logic [23:0] rd;
    logic        err;
    int          waits, base;

    // Status = {result, done, busy, ctrl_start}; expectations follow the sequence order.
    tbl.push_back(mk(1, 1,    'h0A0B0C, 0, 0, 0,        0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4096, 'h00FFEE, 0, 0, 0,        0, 0, 1, 0, 4095));
    tbl.push_back(mk(1, 5,    'h123456, 0, 0, 0,        0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 5,    0,        0, 0, 'h123456, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0,    0,        0, 0, 'h0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,    1,        0, 0, 0,        0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0,    0,        0, 0, 'h3,      0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,    1,        0, 0, 0,        1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2,    'h111111, 0, 0, 0,        1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,    0,        1, 1, 'h3,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,    0,        0, 0, 'hD,      0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3,    'h222222, 0, 0, 0,        0, 0, 1, 0, 2));
    tbl.push_back(mk(1, 4097, 'hABCDEF, 0, 0, 0,        1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4097, 0,        0, 0, 0,        1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3,    0,        0, 0, 'h222222, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 4096, 0,        0, 0, 'h00FFEE, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0,    1,        0, 0, 0,        0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6,    'h333333, 1, 0, 0,        1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,    0,        0, 0, 'h5,      0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,    0,        0, 0, 0,        0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,    0,        0, 0, 'h4,      0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,    1,        0, 0, 0,        0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0,    0,        0, 0, 0,        0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,    0,        0, 0, 'h2,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,    0,        1, 1, 'h2,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,    0,        0, 0, 'hC,      0, 0, 0, 0, 0));

    // Reset asserted at 7ns in the access phase of a write.
    rst = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    done_i = 0; result_i = 0;
    #1 rst = 0;
    #2 rst = 1;
    PSEL = 1; PWRITE = 1; PADDR = 13'd1; PWDATA = 24'hA5A5A5;
    #3 PENABLE = 1;
    #1 rst = 0;
    #1 check_reset_outputs("rst1");
    #14 rst = 1;
    repeat (3) @(negedge clk);
    check("rst1_no_mem_we", 32'(we_count), 32'd0);
    PSEL = 0; PENABLE = 0;

    foreach (tbl[i]) begin
      apb(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].wd, tbl[i].res, rd, err, waits);
      check($sformatf("t%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      check($sformatf("t%0d_waits", i), 32'(waits), 32'(tbl[i].exp_waits));
      if (!tbl[i].w) check($sformatf("t%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
      check($sformatf("t%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].exp_we));
      check($sformatf("t%0d_start", i), 32'(start_o), 32'(tbl[i].exp_st));
      if (tbl[i].exp_we) begin
        check($sformatf("t%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].exp_maddr));
        check($sformatf("t%0d_mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].d));
      end
      if (tbl[i].exp_we) exp_we_total++;
      if (tbl[i].exp_st) exp_st_total++;
    end

    // Reset mid-write after activity: everything returns to reset values.
    base = we_count;
    @(negedge clk);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 13'd9; PWDATA = 24'h777777;
    @(negedge clk);
    PENABLE = 1;
    #2 rst = 0;
    #1 check_reset_outputs("rst2");
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst2_no_mem_we", 32'(we_count - base), 32'd0);
    PSEL = 0; PENABLE = 0;
    m_busy = 0; m_done = 0; m_res = 0; m_ctrl = 0;
    step(0, 13'd0, 24'd0, 0, 0);

    // PENABLE held high over several cycles writes exactly once.
    base = we_count;
    @(negedge clk);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 13'd10; PWDATA = 24'h5A5A5A;
    @(negedge clk);
    PENABLE = 1;
    repeat (4) @(negedge clk);
    PSEL = 0; PENABLE = 0;
    @(negedge clk);
    check("hold_penable_one_write", 32'(we_count - base), 32'd1);
    exp_we_total++;

    for (int i = 0; i < 8; i++) begin
      img_list[i]     = 13'(i + 1);
      img_list[i + 8] = 13'(4089 + i);
    end
    for (int i = 0; i < 16; i++) step(1, img_list[i], 24'($urandom), 0, 0);

    for (int n = 0; n < 200; n++) begin
      logic [12:0] a;
      bit w, wd;
      case ($urandom_range(0, 9))
        0, 1, 2:       a = 13'd0;
        3, 4, 5, 6, 7: a = img_list[$urandom_range(0, 15)];
        default:       a = 13'(4097 + $urandom_range(0, 4094));
      endcase
      w  = 1'($urandom_range(0, 1));
      wd = m_busy && ($urandom_range(0, 3) == 0);
      step(w, a, 24'($urandom), wd, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    check("total_mem_we_pulses", 32'(we_count), 32'(exp_we_total));
    check("total_start_pulses", 32'(st_count), 32'(exp_st_total));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
